// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, oversampled bit timing with
// 2-of-3 majority voting, optional parity, 1 or 2 stop bits, and a one-deep
// valid/ready holding register that reports discarded frames as overrun.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned SAMP_A  = OVERSAMPLE / 2 - 1;
  localparam int unsigned SAMP_B  = OVERSAMPLE / 2;
  localparam int unsigned SAMP_C  = OVERSAMPLE / 2 + 1;
  localparam int unsigned LAST_T  = OVERSAMPLE - 1;
  localparam logic        HAS_PAR = (PARITY != 0);
  localparam logic        ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q;
  logic                 rx_s1_q;
  logic                 rx_s2_q;
  logic [DIV_W-1:0]     div_cnt_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 samp_a_q;
  logic                 samp_b_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_acc_q;
  logic                 ferr_acc_q;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic rx_sync_c;
  logic tick_c;
  logic decide_c;
  logic bit_end_c;
  logic maj_c;
  logic last_stop_c;
  logic done_c;
  logic ferr_c;
  logic perr_c;

  // Sample strobes, majority vote and frame-completion decode.
  always_comb begin
    rx_sync_c   = rx_s2_q;
    tick_c      = (div_cnt_q == DIV_W'(DIV - 1));
    decide_c    = tick_c && (tick_cnt_q == TICK_W'(SAMP_C));
    bit_end_c   = tick_c && (tick_cnt_q == TICK_W'(LAST_T));
    maj_c       = (samp_a_q & samp_b_q) | (samp_a_q & rx_sync_c) | (samp_b_q & rx_sync_c);
    last_stop_c = (stop_cnt_q == 1'(STOP_BITS - 1));
    done_c      = (state_q == S_STOP) && decide_c && last_stop_c;
    ferr_c      = ferr_acc_q | ~maj_c;
    perr_c      = (^shift_q) ^ maj_c ^ ODD_PAR;
  end

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Tick divider and per-bit tick counter; both held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
    end else begin
      if (state_q == S_IDLE) begin
        div_cnt_q  <= '0;
        tick_cnt_q <= '0;
      end else if (tick_c) begin
        div_cnt_q  <= '0;
        tick_cnt_q <= (tick_cnt_q == TICK_W'(LAST_T)) ? '0 : tick_cnt_q + 1'b1;
      end else begin
        div_cnt_q  <= div_cnt_q + 1'b1;
      end
      if (tick_c && (tick_cnt_q == TICK_W'(SAMP_A))) samp_a_q <= rx_sync_c;
      if (tick_c && (tick_cnt_q == TICK_W'(SAMP_B))) samp_b_q <= rx_sync_c;
    end
  end

  // Frame sequencing: start validation, data shift, parity check, stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_cnt_q  <= '0;
          stop_cnt_q <= 1'b0;
          perr_acc_q <= 1'b0;
          ferr_acc_q <= 1'b0;
          if (!rx_sync_c) state_q <= S_START;
        end
        S_START: begin
          if (decide_c && maj_c) begin
            state_q <= S_IDLE;
          end else if (bit_end_c) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (decide_c) shift_q <= {maj_c, shift_q[DATA_BITS-1:1]};
          if (bit_end_c) begin
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              state_q    <= HAS_PAR ? S_PARITY : S_STOP;
              stop_cnt_q <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (decide_c) perr_acc_q <= perr_c;
          if (bit_end_c) state_q <= S_STOP;
        end
        S_STOP: begin
          if (decide_c) begin
            ferr_acc_q <= ferr_c;
            if (last_stop_c) state_q <= S_IDLE;
          end else if (bit_end_c) begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_c) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          parity_err_q <= HAS_PAR & perr_acc_q;
          frame_err_q  <= ferr_c;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
